// File: rtl/game_if.sv
// rtl/game_if.sv - game_ctrl handshake and status bundle
interface game_if;
  logic       START;
  logic       OK;
  logic [7:0] Q_NUM;
  logic       Q_VALID;
  logic [3:0] ANS;
  logic       ANS_VALID;
  logic [3:0] STATE;
  logic       READY_1P;
  logic       Q_REQ;
  logic [3:0] SEC;
  logic [1:0] SCORE;
  logic [1:0] MISS;

  modport master (
    output START, OK, Q_NUM, Q_VALID, ANS, ANS_VALID,
    input  STATE, READY_1P, Q_REQ, SEC, SCORE, MISS
  );

  modport slave (
    input  START, OK, Q_NUM, Q_VALID, ANS, ANS_VALID,
    output STATE, READY_1P, Q_REQ, SEC, SCORE, MISS
  );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - round sequencer for the factorization game
// Ready handshake, countdown, question fetch, answer window, iterative divisibility judge.
module game_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int COUNTDOWN_S = 3,
  parameter int ANSWER_S    = 9,
  parameter int RESULT_S    = 2,
  parameter int WIN_SCORE   = 3,
  parameter int LOSE_MISS   = 3
) (
  input logic   CLK,
  input logic   RST,
  game_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_WAIT   = 4'b0001,
    S_COUNT  = 4'b0010,
    S_QREQ   = 4'b0011,
    S_ANSWER = 4'b0100,
    S_JUDGE  = 4'b0101,
    S_DRAW   = 4'b0110,
    S_GOOD   = 4'b1000,
    S_OUCH   = 4'b1001,
    S_WIN    = 4'b1010,
    S_LOSE   = 4'b1011
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [3:0]    state;
  logic [PW-1:0] presc;
  logic [3:0]    sec;
  logic [3:0]    hold;
  logic [1:0]    score;
  logic [1:0]    miss;
  logic          ready_1p;
  logic          q_req;
  logic [7:0]    q_lat;
  logic [7:0]    rem;
  logic [3:0]    ans_lat;

  logic          tick;
  logic [7:0]    ans_ext;
  logic [1:0]    score_inc;
  logic [1:0]    miss_inc;
  logic          fast_reject;

  assign tick        = (presc == PW'(TICK_DIV - 1));
  assign ans_ext     = {4'd0, ans_lat};
  assign score_inc   = (score == 2'd3) ? score : score + 2'd1;
  assign miss_inc    = (miss == 2'd3) ? miss : miss + 2'd1;
  assign fast_reject = (ans_lat < 4'd2) || (ans_ext >= q_lat);

  assign bus.STATE    = state;
  assign bus.READY_1P = ready_1p;
  assign bus.Q_REQ    = q_req;
  assign bus.SEC      = sec;
  assign bus.SCORE    = score;
  assign bus.MISS     = miss;

  // Every branch that changes state also clears presc so the first second is full length.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      presc    <= '0;
      sec      <= 4'd0;
      hold     <= 4'd0;
      score    <= 2'd0;
      miss     <= 2'd0;
      ready_1p <= 1'b0;
      q_req    <= 1'b0;
      q_lat    <= 8'd0;
      rem      <= 8'd0;
      ans_lat  <= 4'd0;
    end else begin
      ready_1p <= 1'b0;
      q_req    <= 1'b0;
      presc    <= tick ? '0 : presc + PW'(1);
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            ready_1p <= 1'b1;
            score    <= 2'd0;
            miss     <= 2'd0;
            state    <= S_WAIT;
            presc    <= '0;
          end
        end
        S_WAIT: begin
          if (bus.OK) begin
            sec   <= 4'(COUNTDOWN_S);
            state <= S_COUNT;
            presc <= '0;
          end
        end
        S_COUNT: begin
          if (tick) begin
            if (sec == 4'd1) begin
              q_req <= 1'b1;
              sec   <= 4'd0;
              state <= S_QREQ;
              presc <= '0;
            end else begin
              sec <= sec - 4'd1;
            end
          end
        end
        S_QREQ: begin
          if (bus.Q_VALID) begin
            q_lat <= bus.Q_NUM;
            sec   <= 4'(ANSWER_S);
            state <= S_ANSWER;
            presc <= '0;
          end
        end
        S_ANSWER: begin
          // An answer arriving on the final tick still counts.
          if (bus.ANS_VALID) begin
            ans_lat <= bus.ANS;
            rem     <= q_lat;
            sec     <= 4'd0;
            state   <= S_JUDGE;
            presc   <= '0;
          end else if (tick) begin
            if (sec == 4'd1) begin
              sec   <= 4'd0;
              miss  <= miss_inc;
              hold  <= 4'(RESULT_S);
              state <= S_DRAW;
              presc <= '0;
            end else begin
              sec <= sec - 4'd1;
            end
          end
        end
        S_JUDGE: begin
          if (fast_reject) begin
            miss  <= miss_inc;
            hold  <= 4'(RESULT_S);
            state <= S_OUCH;
            presc <= '0;
          end else if (rem >= ans_ext) begin
            rem <= rem - ans_ext;
          end else if (rem == 8'd0) begin
            score <= score_inc;
            hold  <= 4'(RESULT_S);
            state <= S_GOOD;
            presc <= '0;
          end else begin
            miss  <= miss_inc;
            hold  <= 4'(RESULT_S);
            state <= S_OUCH;
            presc <= '0;
          end
        end
        S_DRAW, S_GOOD, S_OUCH: begin
          if (tick) begin
            if (hold == 4'd1) begin
              presc <= '0;
              if (score == 2'(WIN_SCORE)) begin
                state <= S_WIN;
              end else if (miss == 2'(LOSE_MISS)) begin
                state <= S_LOSE;
              end else begin
                ready_1p <= 1'b1;
                state    <= S_WAIT;
              end
            end else begin
              hold <= hold - 4'd1;
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (bus.START) begin
            state <= S_IDLE;
            presc <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          sec   <= 4'd0;
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl
// Stimulus pushes expected state transitions; a monitor pops them on every STATE change.
module tb_game_ctrl;

  localparam int TICK = 4;
  localparam logic [3:0] ST_IDLE = 4'b0000, ST_WAIT = 4'b0001, ST_COUNT = 4'b0010;
  localparam logic [3:0] ST_QREQ = 4'b0011, ST_ANSWER = 4'b0100, ST_JUDGE = 4'b0101;
  localparam logic [3:0] ST_DRAW = 4'b0110, ST_GOOD = 4'b1000, ST_OUCH = 4'b1001;
  localparam logic [3:0] ST_WIN = 4'b1010, ST_LOSE = 4'b1011;

  typedef struct {
    logic [3:0] st;
    int         dwell;
    logic [1:0] score;
    logic [1:0] miss;
    logic       rdy;
    logic       qrq;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  game_if bus ();

  game_ctrl #(.TICK_DIV(TICK)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // Ready block stand-in: OK follows READY_1P one cycle later.
  always @(posedge CLK or negedge RST) begin
    if (!RST) bus.OK <= 1'b0;
    else      bus.OK <= bus.READY_1P;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  bit   mon_en  = 0;
  int   m_score = 0;
  int   m_miss  = 0;
  bit   over    = 0;
  logic [3:0] m_end = ST_WIN;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void push(input logic [3:0] st, input int dwell, input logic rdy, input logic qrq);
    exp_t e;
    e.st = st; e.dwell = dwell; e.rdy = rdy; e.qrq = qrq;
    e.score = 2'(m_score); e.miss = 2'(m_miss);
    exp_q.push_back(e);
  endfunction

  // Monitor: compare on every STATE change, and SEC / pulse levels every cycle.
  initial begin
    bit         was = 0;
    logic [3:0] prev_st = 4'd0;
    int         cnt = 0;
    int         exp_sec;
    exp_t       e;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        was = 0;
      end else begin
        if (!was) begin
          prev_st = bus.STATE; cnt = 1; was = 1;
        end else if (bus.STATE != prev_st) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_transition @%0t: got %0d, expected %0d", $time, bus.STATE, prev_st);
          end else begin
            e = exp_q.pop_front();
            chk("state", bus.STATE, e.st);
            chk("score", bus.SCORE, e.score);
            chk("miss", bus.MISS, e.miss);
            chk("ready_1p_entry", bus.READY_1P, e.rdy);
            chk("q_req_entry", bus.Q_REQ, e.qrq);
            if (e.dwell >= 0) chk("dwell", cnt, e.dwell);
          end
          prev_st = bus.STATE; cnt = 1;
        end else begin
          cnt++;
          chk("ready_1p_low", bus.READY_1P, 0);
          chk("q_req_low", bus.Q_REQ, 0);
        end
        if (bus.STATE == ST_COUNT)       exp_sec = 3 - (cnt - 1) / TICK;
        else if (bus.STATE == ST_ANSWER) exp_sec = 9 - (cnt - 1) / TICK;
        else                             exp_sec = 0;
        chk("sec", bus.SEC, exp_sec);
      end
    end
  end

  task automatic wait_state(input logic [3:0] s, input int lim, input string name);
    int n = 0;
    while (bus.STATE !== s && n < lim) begin @(negedge CLK); n++; end
    if (n >= lim) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout @%0t: got %0d, expected %0d", name, $time, bus.STATE, s);
    end
  endtask

  task automatic wait_qreq();
    int n = 0;
    while (bus.Q_REQ !== 1'b1 && n < 400) begin @(negedge CLK); n++; end
    if (n >= 400) begin
      n_tests++; n_fail++;
      $display("FAIL qreq_timeout @%0t: got %0d, expected 1", $time, bus.Q_REQ);
    end
  endtask

  task automatic start_game();
    m_score = 0; m_miss = 0; over = 0;
    bus.START = 1'b1;
    push(ST_WAIT, -1, 1'b1, 1'b0);
    @(negedge CLK);
    bus.START = 1'b0;
    bus.ANS = 4'($urandom); bus.ANS_VALID = 1'b1;
    @(negedge CLK);
    bus.ANS_VALID = 1'b0;
  endtask

  task automatic finish_game();
    wait_state(m_end, 400, "end_state");
    repeat ($urandom_range(0, 2)) @(negedge CLK);
    bus.START = 1'b1;
    push(ST_IDLE, -1, 1'b0, 1'b0);
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
  endtask

  // k < 0: no answer; otherwise ANS_VALID lands k cycles after ANSWER entry (35 = final tick).
  task automatic play_round(input int q, input int a, input int k);
    int d, lat;
    logic [3:0] res;
    push(ST_COUNT, 2, 1'b0, 1'b0);
    push(ST_QREQ, 3 * TICK, 1'b0, 1'b1);
    wait_qreq();
    d = $urandom_range(0, 3);
    repeat (d) @(negedge CLK);
    bus.Q_NUM = 8'(q); bus.Q_VALID = 1'b1;
    push(ST_ANSWER, d + 1, 1'b0, 1'b0);
    @(negedge CLK);
    bus.Q_VALID = 1'b0; bus.Q_NUM = 8'($urandom);
    if (k < 0) begin
      m_miss = (m_miss < 3) ? m_miss + 1 : 3;
      push(ST_DRAW, 9 * TICK, 1'b0, 1'b0);
    end else begin
      repeat (k) @(negedge CLK);
      bus.ANS = 4'(a); bus.ANS_VALID = 1'b1;
      push(ST_JUDGE, k + 1, 1'b0, 1'b0);
      if (a < 2 || a >= q) begin
        res = ST_OUCH; lat = 1;
      end else begin
        lat = q / a + 1;
        res = (q % a == 0) ? ST_GOOD : ST_OUCH;
      end
      if (res == ST_GOOD) m_score = (m_score < 3) ? m_score + 1 : 3;
      else                m_miss  = (m_miss < 3) ? m_miss + 1 : 3;
      push(res, lat, 1'b0, 1'b0);
      @(negedge CLK);
      bus.ANS_VALID = 1'b0; bus.ANS = 4'($urandom);
    end
    if (m_score == 3) begin
      over = 1; m_end = ST_WIN; push(ST_WIN, 2 * TICK, 1'b0, 1'b0);
    end else if (m_miss == 3) begin
      over = 1; m_end = ST_LOSE; push(ST_LOSE, 2 * TICK, 1'b0, 1'b0);
    end else begin
      push(ST_WAIT, 2 * TICK, 1'b1, 1'b0);
    end
  endtask

  task automatic round(input int q, input int a, input int k);
    if (over) begin
      finish_game();
      start_game();
    end
    play_round(q, a, k);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, bus.STATE, 0);
    chk({tag, "_sec"}, bus.SEC, 0);
    chk({tag, "_score"}, bus.SCORE, 0);
    chk({tag, "_miss"}, bus.MISS, 0);
    chk({tag, "_ready_1p"}, bus.READY_1P, 0);
    chk({tag, "_q_req"}, bus.Q_REQ, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog @%0t: simulation did not complete", $time);
    $fatal(1);
  end

  initial begin
    int n;
    RST = 1'b0;
    bus.START = 1'b0; bus.Q_NUM = 8'd0; bus.Q_VALID = 1'b0;
    bus.ANS = 4'd0; bus.ANS_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b1;
    mon_en = 1;
    repeat (2) @(negedge CLK);

    start_game();
    round(15, 3, $urandom_range(0, 20));
    round(15, 4, $urandom_range(0, 20));
    round(15, 1, $urandom_range(0, 20));
    round(15, 15, $urandom_range(0, 20));
    round(30, 5, -1);
    round(12, 4, 35);
    round(14, 7, 0);
    round(9, 3, 35);
    for (int i = 0; i < 14; i++) begin
      int q, a, k;
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(2, 15);
        q = a * $urandom_range(1, 255 / a);
      end else begin
        a = $urandom_range(0, 15);
        q = $urandom_range(0, 255);
      end
      k = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 35);
      round(q, a, k);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin @(negedge CLK); n++; end
    chk("queue_drained", exp_q.size(), 0);

    mon_en = 0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    RST = 1'b1;
    mon_en = 1;
    repeat (2) @(negedge CLK);
    start_game();
    play_round(20, 5, $urandom_range(0, 10));
    play_round(120, 2, 3);
    repeat (20) @(negedge CLK);
    chk("mid_judge_state", bus.STATE, ST_JUDGE);
    chk("mid_judge_score", bus.SCORE, 1);
    mon_en = 0;
    RST = 1'b0;
    #1;
    check_all_zero("async_reset");
    chk("async_reset_rem", dut.rem, 0);
    @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_reset_state", bus.STATE, ST_IDLE);
      chk("post_reset_ready_1p", bus.READY_1P, 0);
    end

    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_state(ST_COUNT, 10, "count_entry");
    @(negedge CLK);
    force dut.state = 4'b0111;
    @(posedge CLK);
    #1 release dut.state;
    @(posedge CLK);
    #1;
    chk("unused_code_state", bus.STATE, ST_IDLE);
    chk("unused_code_sec", bus.SEC, 0);

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Round sequencer for the factorization game. It drives the 4-bit `STATE` bus that the ready block and the display consume. It walks one player through each phase of a game: ready handshake, countdown, question fetch, answer window, divisibility judgement, result display, then win or lose. Judging is sequential: an iterative subtract-remainder loop checks whether the player's factor divides the question number.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per 1-second tick.
- `COUNTDOWN_S`, 3: countdown length in seconds (1–15).
- `ANSWER_S`, 9: answer window in seconds (1–15).
- `RESULT_S`, 2: hold time of GOOD/OUCH/DRAW in seconds (1–15).
- `WIN_SCORE`, 3: GOOD count that ends the game in WIN (1–3).
- `LOSE_MISS`, 3: OUCH+DRAW count that ends the game in LOSE (1–3).

Ports:
- `CLK`  in  1  system clock; the block has one clock.
- `RST`  in  1  reset; asynchronous, active-low.
- `START`  in  1  single-cycle pulse from the debounced start button.
- `OK`  in  1  level from the ready block; high once both players are ready.
- `Q_NUM`  in  8  question number from the problem generator.
- `Q_VALID`  in  1  `Q_NUM` is valid this cycle.
- `ANS`  in  4  factor entered by the player.
- `ANS_VALID`  in  1  single-cycle pulse; `ANS` is valid.
- `STATE`  out  4  current game state (registered).
- `READY_1P`  out  1  single-cycle pulse requesting the ready handshake.
- `Q_REQ`  out  1  single-cycle pulse requesting a new question.
- `SEC`  out  4  remaining seconds in COUNT or ANSWER; 0 elsewhere.
- `SCORE`  out  2  GOOD count.
- `MISS`  out  2  OUCH+DRAW count.

## Operation
- State encodings:
  - IDLE 0000, WAIT 0001, COUNT 0010, QREQ 0011, ANSWER 0100, JUDGE 0101.
  - DRAW 0110, GOOD 1000, OUCH 1001, WIN 1010, LOSE 1011.
  - Unused codes (0111, 1100–1111) go to IDLE on the next clock.
- IDLE: on `START`, pulse `READY_1P`, clear `SCORE` and `MISS`, go to WAIT.
- WAIT: on `OK`=1, go to COUNT and load `SEC`=`COUNTDOWN_S`.
- COUNT: each tick decrements `SEC`. A tick with `SEC`=1 pulses `Q_REQ`, sets `SEC`=0 and goes to QREQ.
- QREQ: on `Q_VALID`, latch `Q_NUM`, load `SEC`=`ANSWER_S`, go to ANSWER.
- ANSWER:
  - `ANS_VALID` latches `ANS` and goes to JUDGE.
  - A tick with `SEC`=1 goes to DRAW.
  - If both happen in the same cycle, the answer wins.
- JUDGE:
  - If `ANS`<2 or `ANS`≥`Q_NUM`, go to OUCH on the next clock.
  - Otherwise load remainder `rem`=`Q_NUM`, then subtract `ANS` once per cycle while `rem`≥`ANS`.
  - When `rem`<`ANS`: `rem`=0 goes to GOOD, otherwise OUCH.
  - `rem` is 8 bits. The subtraction only happens when `rem`≥`ANS`, so it never underflows.
- Counters on entry:
  - GOOD increments `SCORE`.
  - OUCH and DRAW increment `MISS`.
  - Both counters saturate at 3.
- GOOD/OUCH/DRAW hold for `RESULT_S` ticks. `SEC` stays 0 here; an internal hold counter does the timing. On expiry:
  - `SCORE`=`WIN_SCORE` goes to WIN.
  - Otherwise `MISS`=`LOSE_MISS` goes to LOSE.
  - Otherwise pulse `READY_1P` and go to WAIT. The ready block drops `OK` during result states, so every round re-handshakes.
- WIN/LOSE: hold until `START`, then go to IDLE. That `START` is consumed and does not start a new game in the same cycle.
- `START`, `ANS_VALID` and `Q_VALID` are ignored outside the states listed above.

## Timing
- Reset values: `STATE`=0000, `READY_1P`=0, `Q_REQ`=0, `SEC`=0, `SCORE`=0, `MISS`=0. The prescaler, hold counter, `rem` and latches are also 0.
- All outputs are registered and update on the clock edge after the triggering input.
- Prescaler:
  - Counts 0..`TICK_DIV`-1; the tick fires when it reaches `TICK_DIV`-1.
  - It clears on every state change, so the first second in any state is a full `TICK_DIV` cycles.
- COUNT lasts exactly `COUNTDOWN_S`×`TICK_DIV` cycles after entry.
- `READY_1P` and `Q_REQ` are high for exactly one cycle, asserted on the same edge as the state change.
- JUDGE latency is floor(`Q_NUM`/`ANS`)+1 cycles, measured from JUDGE entry to the GOOD/OUCH transition. The fast-reject path takes 1 cycle.
- Asserting `RST` mid-operation (e.g. mid-JUDGE) returns everything to reset values immediately. No pulse is emitted on release.

## Test plan
- Bench setup: `TICK_DIV`=4, `OK` tied to `READY_1P`-delayed-1.
- Full path: `START` → `READY_1P` one cycle, WAIT, COUNT 12 cycles with `SEC` 3→2→1, one `Q_REQ` pulse, QREQ.
- `Q_NUM`=15, `ANS`=3 → JUDGE for 6 cycles → GOOD, `SCORE`=1. After 8 cycles in GOOD, WAIT with a `READY_1P` pulse.
- `Q_NUM`=15 with `ANS`=4 → OUCH (`MISS`=1). `ANS`=1 → OUCH after 1 JUDGE cycle. `ANS`=15 → OUCH.
- No answer in ANSWER → DRAW after 36 cycles, `MISS`+1. `ANS_VALID` on the same cycle as the final tick → JUDGE.
- Three GOODs → WIN. Three misses → LOSE. `START` in WIN → IDLE, with `SCORE`=`MISS`=0 after the next `START`.
- `RST` low during JUDGE with `Q_NUM`=120, `ANS`=2 → `STATE`=0000 and all outputs 0 immediately. `STATE` 0111 forced by bench → IDLE next clock.
